mem_port_arbiter: RTL and testbench

Shares the single-port unified instruction/data/frame memory between three requesters: instruction fetch (ifu), load/store from the memory stage (dat, driven by memRead/memWrite decode), and video scan-out (vid). Issues at most one access per cycle and returns read data through a pipeline of owner tags that tracks the fixed memory read latency. Video gets a bounded-wait guarantee so the display never underruns.

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_if.sv | 28 ++
 rtl/mem_port_arbiter_rd_tag_pipe.sv | 23 ++
 rtl/mem_port_arbiter.sv | 53 +++++
 tb/tb_mem_port_arbiter.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: owner tags, default parameters and the wait-counter width helper
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFU  = 2'd1,
    OWN_DAT  = 2'd2,
    OWN_VID  = 2'd3
  } own_t;
  localparam int ADDR_W_DEF       = 16;
  localparam int DATA_W_DEF       = 32;
  localparam int RD_LAT_DEF       = 2;
  localparam int VID_MAX_WAIT_DEF = 3;
  // A zero max wait still needs a one-bit counter so the compare stays legal.
  function automatic int wait_w(input int max_wait);
    return max_wait > 0 ? $clog2(max_wait + 1) : 1;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshakes plus the single memory port
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              ifu_req, ifu_gnt, ifu_rvalid;
  logic [ADDR_W-1:0] ifu_addr;
  logic [DATA_W-1:0] ifu_rdata;
  logic              dat_req, dat_we, dat_gnt, dat_rvalid;
  logic [ADDR_W-1:0] dat_addr;
  logic [DATA_W-1:0] dat_wdata, dat_rdata;
  logic              vid_req, vid_gnt, vid_rvalid;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  modport slave (
    input  ifu_req, ifu_addr, dat_req, dat_we, dat_addr, dat_wdata, vid_req, vid_addr, mem_rdata,
    output ifu_gnt, ifu_rvalid, ifu_rdata, dat_gnt, dat_rvalid, dat_rdata,
           vid_gnt, vid_rvalid, vid_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output ifu_req, ifu_addr, dat_req, dat_we, dat_addr, dat_wdata, vid_req, vid_addr, mem_rdata,
    input  ifu_gnt, ifu_rvalid, ifu_rdata, dat_gnt, dat_rvalid, dat_rdata,
           vid_gnt, vid_rvalid, vid_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: owner-tag shift register matching the memory read latency
module rd_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  own_t in_tag,
  output own_t out_tag
);
  own_t r_pipe [RD_LAT];
  // Shift one tag per cycle; reset drops every in-flight read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < RD_LAT; k++) r_pipe[k] <= OWN_NONE;
    end else begin
      r_pipe[0] <= in_tag;
      for (int k = 1; k < RD_LAT; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end
  assign out_tag = r_pipe[RD_LAT-1];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-port memory arbiter for fetch, load/store and video with bounded video wait
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int RD_LAT       = RD_LAT_DEF,
  parameter int VID_MAX_WAIT = VID_MAX_WAIT_DEF
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.slave  bus
);
  localparam int VW = wait_w(VID_MAX_WAIT);
  logic [VW-1:0] r_vid_wait;
  logic          w_vid_urgent, w_ifu_gnt, w_dat_gnt, w_vid_gnt;
  own_t          w_in_tag, w_out_tag;
  // Fixed priority dat > ifu > vid, overridden by video once it has waited its limit.
  always_comb begin
    w_vid_urgent = bus.vid_req && (r_vid_wait == VW'(VID_MAX_WAIT));
    w_dat_gnt    = !reset && bus.dat_req && !w_vid_urgent;
    w_ifu_gnt    = !reset && bus.ifu_req && !bus.dat_req && !w_vid_urgent;
    w_vid_gnt    = !reset && bus.vid_req && (w_vid_urgent || (!bus.dat_req && !bus.ifu_req));
    w_in_tag     = (w_dat_gnt && !bus.dat_we) ? OWN_DAT :
                   w_ifu_gnt ? OWN_IFU : w_vid_gnt ? OWN_VID : OWN_NONE;
  end
  // Count refused video cycles, saturating at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_vid_wait <= '0;
    else if (!bus.vid_req || w_vid_gnt) r_vid_wait <= '0;
    else if (r_vid_wait != VW'(VID_MAX_WAIT)) r_vid_wait <= r_vid_wait + 1'b1;
  end
  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .in_tag  (w_in_tag),
    .out_tag (w_out_tag)
  );
  assign bus.ifu_gnt    = w_ifu_gnt;
  assign bus.dat_gnt    = w_dat_gnt;
  assign bus.vid_gnt    = w_vid_gnt;
  assign bus.mem_en     = w_ifu_gnt || w_dat_gnt || w_vid_gnt;
  assign bus.mem_we     = w_dat_gnt && bus.dat_we;
  assign bus.mem_addr   = w_dat_gnt ? bus.dat_addr : w_ifu_gnt ? bus.ifu_addr :
                          w_vid_gnt ? bus.vid_addr : '0;
  assign bus.mem_wdata  = w_dat_gnt ? bus.dat_wdata : '0;
  assign bus.ifu_rvalid = !reset && w_out_tag == OWN_IFU;
  assign bus.dat_rvalid = !reset && w_out_tag == OWN_DAT;
  assign bus.vid_rvalid = !reset && w_out_tag == OWN_VID;
  assign bus.ifu_rdata  = bus.ifu_rvalid ? bus.mem_rdata : '0;
  assign bus.dat_rdata  = bus.dat_rvalid ? bus.mem_rdata : '0;
  assign bus.vid_rdata  = bus.vid_rvalid ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven directed vectors plus reset corner sequences
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();
  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(2), .VID_MAX_WAIT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  req;
    logic        we;
    logic [15:0] ia, da, va;
    logic [31:0] wd, md;
    logic [2:0]  egnt;
    logic        ewe;
    logic [15:0] eaddr;
    logic [31:0] ewd;
    logic [2:0]  erv;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t v(input logic [2:0] req, input logic we, input logic [15:0] ia, da, va,
                             input logic [31:0] wd, md, input logic [2:0] egnt, input logic ewe,
                             input logic [15:0] eaddr, input logic [31:0] ewd, input logic [2:0] erv);
    vec_t r;
    r.req = req; r.we = we; r.ia = ia; r.da = da; r.va = va; r.wd = wd; r.md = md;
    r.egnt = egnt; r.ewe = ewe; r.eaddr = eaddr; r.ewd = ewd; r.erv = erv;
    return r;
  endfunction

  function automatic vec_t idle(input logic [31:0] md, input logic [2:0] erv);
    return v(3'b000, 1'b0, 16'h0, 16'h0, 16'h0, 32'h0, md, 3'b000, 1'b0, 16'h0, 32'h0, erv);
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] req, input logic we, input logic [15:0] ia, da, va,
                       input logic [31:0] wd, md);
    bus.ifu_req = req[2]; bus.dat_req = req[1]; bus.vid_req = req[0];
    bus.dat_we = we; bus.ifu_addr = ia; bus.dat_addr = da; bus.vid_addr = va;
    bus.dat_wdata = wd; bus.mem_rdata = md;
  endtask

  function automatic logic [2:0] gnts();
    return {bus.ifu_gnt, bus.dat_gnt, bus.vid_gnt};
  endfunction

  function automatic logic [2:0] rvs();
    return {bus.ifu_rvalid, bus.dat_rvalid, bus.vid_rvalid};
  endfunction

  initial begin
    // Test 1: solo fetch
    vecs.push_back(v(3'b100, 0, 16'h0040, 16'h0, 16'h0, 32'h0, 32'h0, 3'b100, 0, 16'h0040, 32'h0, 3'b000));
    vecs.push_back(idle(32'h0, 3'b000));
    vecs.push_back(idle(32'hDEADBEEF, 3'b100));
    vecs.push_back(idle(32'hDEADBEEF, 3'b000));
    // Test 2: load beats fetch; fetch address changes while refused
    vecs.push_back(v(3'b110, 0, 16'h0041, 16'h0100, 16'h0, 32'h0, 32'h0, 3'b010, 0, 16'h0100, 32'h0, 3'b000));
    vecs.push_back(v(3'b100, 0, 16'h0042, 16'h0, 16'h0, 32'h0, 32'h0, 3'b100, 0, 16'h0042, 32'h0, 3'b000));
    vecs.push_back(idle(32'hA1A1A1A1, 3'b010));
    vecs.push_back(idle(32'hA2A2A2A2, 3'b100));
    vecs.push_back(idle(32'hA3A3A3A3, 3'b000));
    // Test 3: store produces no return
    vecs.push_back(v(3'b010, 1, 16'h0, 16'h0200, 16'h0, 32'h12345678, 32'h0, 3'b010, 1, 16'h0200, 32'h12345678, 3'b000));
    vecs.push_back(idle(32'h0, 3'b000));
    vecs.push_back(idle(32'h55555555, 3'b000));
    // Test 4: continuous loads starve video until it turns urgent
    vecs.push_back(v(3'b011, 0, 16'h0, 16'h0300, 16'h0800, 32'h0, 32'h0, 3'b010, 0, 16'h0300, 32'h0, 3'b000));
    vecs.push_back(v(3'b011, 0, 16'h0, 16'h0300, 16'h0800, 32'h0, 32'h0, 3'b010, 0, 16'h0300, 32'h0, 3'b000));
    vecs.push_back(v(3'b011, 0, 16'h0, 16'h0300, 16'h0800, 32'h0, 32'hB0B0B0B0, 3'b010, 0, 16'h0300, 32'h0, 3'b010));
    vecs.push_back(v(3'b011, 0, 16'h0, 16'h0300, 16'h0800, 32'h0, 32'hB1B1B1B1, 3'b001, 0, 16'h0800, 32'h0, 3'b010));
    vecs.push_back(v(3'b010, 0, 16'h0, 16'h0300, 16'h0, 32'h0, 32'hB2B2B2B2, 3'b010, 0, 16'h0300, 32'h0, 3'b010));
    vecs.push_back(idle(32'hC5C5C5C5, 3'b001));
    vecs.push_back(idle(32'hB6B6B6B6, 3'b010));
    vecs.push_back(idle(32'h0, 3'b000));
    // Test 5: mixed back-to-back owners
    vecs.push_back(v(3'b100, 0, 16'h0010, 16'h0, 16'h0, 32'h0, 32'h0, 3'b100, 0, 16'h0010, 32'h0, 3'b000));
    vecs.push_back(v(3'b001, 0, 16'h0, 16'h0, 16'h0900, 32'h0, 32'h0, 3'b001, 0, 16'h0900, 32'h0, 3'b000));
    vecs.push_back(v(3'b010, 1, 16'h0, 16'h0400, 16'h0, 32'h0000CAFE, 32'hD2D2D2D2, 3'b010, 1, 16'h0400, 32'h0000CAFE, 3'b100));
    vecs.push_back(idle(32'hD3D3D3D3, 3'b001));
    vecs.push_back(idle(32'hD4D4D4D4, 3'b000));

    // Reset state: requests pending but everything held off
    drive(3'b111, 1, 16'h1, 16'h2, 16'h3, 32'h4, 32'h5);
    #12;
    check("reset_gnt", 96'(gnts()), 96'(3'b000));
    check("reset_mem", 96'({bus.mem_en, bus.mem_we}), 96'(2'b00));
    check("reset_rv", 96'(rvs()), 96'(3'b000));
    @(posedge clk); #1;
    reset = 1'b0;
    drive(3'b000, 0, 16'h0, 16'h0, 16'h0, 32'h0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      drive(vecs[i].req, vecs[i].we, vecs[i].ia, vecs[i].da, vecs[i].va, vecs[i].wd, vecs[i].md);
      #3;
      check($sformatf("v%0d_gnt", i), 96'(gnts()), 96'(vecs[i].egnt));
      check($sformatf("v%0d_mem", i), 96'({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}),
            96'({|vecs[i].egnt, vecs[i].ewe, vecs[i].eaddr, vecs[i].ewd}));
      check($sformatf("v%0d_rv", i), 96'(rvs()), 96'(vecs[i].erv));
      check($sformatf("v%0d_rdata", i), {bus.ifu_rdata, bus.dat_rdata, bus.vid_rdata},
            {vecs[i].erv[2] ? vecs[i].md : 32'h0, vecs[i].erv[1] ? vecs[i].md : 32'h0,
             vecs[i].erv[0] ? vecs[i].md : 32'h0});
    end

    // Test 6: build up video wait, grant a fetch, then reset while it is in flight
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      drive(3'b011, 1, 16'h0, 16'h0600, 16'h0A00, 32'h0, 32'h0);
    end
    @(posedge clk); #1;
    drive(3'b101, 0, 16'h0070, 16'h0, 16'h0A00, 32'h0, 32'h0);
    #3;
    check("r6_ifu_gnt", 96'(gnts()), 96'(3'b100));
    @(posedge clk); #1;
    drive(3'b111, 0, 16'h0070, 16'h0600, 16'h0A00, 32'h0, 32'hEEEEEEEE);
    #1;
    check("r6_urgent_before_reset", 96'(gnts()), 96'(3'b001));
    #1;
    reset = 1'b1;
    #1;
    check("r6_gnt_in_reset", 96'(gnts()), 96'(3'b000));
    check("r6_mem_in_reset", 96'({bus.mem_en, bus.mem_we}), 96'(2'b00));
    @(posedge clk); #1;
    check("r6_rv_in_reset", 96'(rvs()), 96'(3'b000));
    @(posedge clk); #1;
    reset = 1'b0;
    drive(3'b001, 0, 16'h0, 16'h0, 16'h0B00, 32'h0, 32'hEEEEEEEE);
    #2;
    check("r6_wait_cleared", 96'(dut.r_vid_wait), 96'(0));
    check("r6_first_cycle_gnt", 96'(gnts()), 96'(3'b001));
    check("r6_first_cycle_addr", 96'(bus.mem_addr), 96'(16'h0B00));
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      drive(3'b000, 0, 16'h0, 16'h0, 16'h0, 32'h0, 32'h77777777);
      #3;
      check($sformatf("r6_post_rv%0d", i), 96'(rvs()), 96'(i == 2 ? 3'b001 : 3'b000));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
